mmv_ram_test_ctrl: RTL
======================

Name: mmv_ram_test_ctrl

Overview:
Session controller that sits directly upstream of the memory data-bus tester. It drives the tester's clear/start control interface and consumes its ready/fault/done outputs. It runs a programmed number of test iterations, counts faults and completed iterations, guards each phase with a watchdog, and reports a single pass/fail verdict per session. It is the block a CPU register file or a test top-level drives in place of manual clear/start pulsing.

Parameters:
CWIDTH, 16, width of the iteration request and of the iteration/fault counters.
TIMEOUT, 65536, watchdog limit in clk cycles per WAIT_RDY or RUN phase (TIMEOUT > 1).
STOP_ON_FAULT, 0, 1 = end the session at the first fault; 0 = run all iterations.

Ports:
reset  in  1  synchronous reset, active high
clk  in  1  clock
run  in  1  session start pulse; ignored while busy
abort  in  1  session abort; ignored in IDLE
iters  in  CWIDTH  iteration count, sampled on accepted run; 0 = continuous until abort
busy  out  1  session in progress
sdone  out  1  one-cycle pulse at session end
spass  out  1  verdict of last session; valid from sdone until next accepted run
iter_cnt  out  CWIDTH  completed iterations, saturating
fault_cnt  out  CWIDTH  fault pulses counted, saturating
timeout  out  1  watchdog expired in this session (sticky until next run)
t_clear  out  1  tester synchronous clear
t_start  out  1  tester start pulse
t_ready  in  1  tester ready
t_fault  in  1  tester fault pulse
t_done  in  1  tester done pulse

Behaviour:
- One clock domain. Reset is synchronous and active high. All outputs are registered.
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- FSM states: IDLE, CLEAR, WAIT_RDY, START, RUN, CHECK, FINISH.
- IDLE:
  - run=1 → CLEAR.
  - Latch iters. Clear iter_cnt, fault_cnt, timeout and spass.
  - busy goes high the cycle after run.
- CLEAR: t_clear=1 for exactly one cycle → WAIT_RDY.
- WAIT_RDY:
  - Watchdog counts from 0.
  - t_ready=1 → START.
  - Watchdog reaches TIMEOUT-1 → set timeout, go to FINISH with t_clear pulsed.
- START: t_start=1 for exactly one cycle; watchdog cleared → RUN.
  - t_start never coincides with t_clear.
  - Minimum run-to-t_start latency is 3 cycles (run at k, t_clear at k+1, t_ready seen at k+2, t_start at k+3).
- RUN:
  - Each t_fault cycle increments fault_cnt (saturating at all-ones).
  - t_done=1 → CHECK. If t_fault and t_done arrive in the same cycle, the fault is counted.
  - STOP_ON_FAULT=1 and t_fault=1 → FINISH with t_clear pulsed.
  - Watchdog expiry → set timeout, FINISH with t_clear pulsed.
- CHECK:
  - iter_cnt increments (saturating).
  - If iters≠0 and the new iter_cnt == latched iters → FINISH.
  - Otherwise → WAIT_RDY. No reclear between iterations; the tester returns to ready on its own.
- FINISH:
  - sdone=1 for one cycle.
  - spass = (fault_cnt==0) & ~timeout & ~aborted.
  - busy drops in the same cycle as sdone. → IDLE.
- abort=1 in any state other than IDLE or FINISH:
  - Next state is FINISH, with t_clear=1 in that FINISH cycle.
  - Aborted flag is set, so spass=0.
  - Counters are held, not cleared.
- Faults and done pulses arriving outside RUN are ignored.
- run while busy is ignored.
- run and abort arriving together in IDLE: run wins, abort is ignored.
- iters is ignored after it is latched.
- Reset mid-session: immediate return to IDLE with reset values. No sdone is issued.

Decomposition:
- Package mmv_ram_test_pkg holds:
  - the FSM state enum typedef (state_t);
  - the watchdog width constant derived from TIMEOUT via $clog2.
- No sub-module. The watchdog is a local counter in the single module. Estimated RTL is about 200 lines.

Test Plan:
- Bench: the controller drives mmv_ram_db_tester (AWIDTH=8, DWIDTH=8), backed by mmv_slave_model in MEMORY mode with RDDELAY=16.
- Pass run: iters=3, run pulse → exactly 3 t_start pulses, iter_cnt=3, fault_cnt=0, one sdone, spass=1, busy low after sdone.
- Fault injection: force m_rdat bit 0 stuck-at-0 during iteration 2 of iters=3, STOP_ON_FAULT=0 → fault_cnt>0, iter_cnt=3, spass=0.
- Stop on fault: STOP_ON_FAULT=1, same fault → sdone within 2 cycles of the first t_fault, t_clear=1 on that cycle, iter_cnt=1, spass=0.
- Timeout: TIMEOUT=64, tie t_ready=0, run → timeout=1 and sdone exactly 64 cycles after entering WAIT_RDY, spass=0, no t_start seen.
- Abort and continuous mode: iters=0, abort 500 cycles after run → t_clear pulse, sdone, spass=0, counters held. Also check that run during busy and reset mid-RUN return to IDLE with all outputs at 0 and no sdone.

Source files
------------

// File: rtl/mmv_ram_test_pkg.sv
// Shared types and sizing helpers for the memory data-bus test session controller.
package mmv_ram_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_START    = 3'd3,
        S_RUN      = 3'd4,
        S_CHECK    = 3'd5,
        S_FINISH   = 3'd6
    } state_t;

    localparam int unsigned DEF_TIMEOUT = 65536;

    // Watchdog holds values 0..timeout-1; keep at least one bit for tiny limits.
    function automatic int unsigned wd_width(input int unsigned timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

    localparam int unsigned DEF_WD_W = wd_width(DEF_TIMEOUT);

endpackage

// File: rtl/mmv_ram_test_ctrl.sv
// Session controller for the memory data-bus tester: sequences clear/start,
// counts iterations and faults, guards each phase with a watchdog, reports a verdict.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for run; verdict of last session held
// CLEAR    | one-cycle tester clear
// WAIT_RDY | waiting for tester ready, watchdog running
// START    | one-cycle tester start
// RUN      | tester busy; count faults, wait for done, watchdog running
// CHECK    | iteration completed; decide next iteration or finish
// FINISH   | one-cycle session end (sdone, verdict), tester cleared if cut short
module mmv_ram_test_ctrl
    import mmv_ram_test_pkg::*;
#(
    parameter int CWIDTH        = 16,
    parameter int TIMEOUT       = 65536,
    parameter bit STOP_ON_FAULT = 1'b0
) (
    input  logic              reset,
    input  logic              clk,
    input  logic              run,
    input  logic              abort,
    input  logic [CWIDTH-1:0] iters,
    output logic              busy,
    output logic              sdone,
    output logic              spass,
    output logic [CWIDTH-1:0] iter_cnt,
    output logic [CWIDTH-1:0] fault_cnt,
    output logic              timeout,
    output logic              t_clear,
    output logic              t_start,
    input  logic              t_ready,
    input  logic              t_fault,
    input  logic              t_done
);

    localparam int WDW = wd_width(TIMEOUT);
    localparam logic [WDW-1:0]    WD_LOAD = WDW'(TIMEOUT - 1);
    localparam logic [CWIDTH-1:0] CMAX    = '1;

    state_t            state, state_nxt;
    logic [WDW-1:0]    wd;
    logic [CWIDTH-1:0] iters_lat;
    logic [CWIDTH-1:0] iter_inc, iter_nxt, fault_nxt;
    logic              aborted, aborted_nxt, timeout_nxt;
    logic              accept, wd_exp, fin_clear, to_timeout, to_abort;
    logic              busy_d, sdone_d, spass_d, t_clear_d, t_start_d;

    assign accept   = (state == S_IDLE) && run;
    assign wd_exp   = (wd == '0);
    assign iter_inc = (iter_cnt == CMAX) ? iter_cnt : iter_cnt + CWIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        fin_clear  = 1'b0;
        to_timeout = 1'b0;
        to_abort   = 1'b0;
        if (abort && state != S_IDLE && state != S_FINISH) begin
            state_nxt = S_FINISH;
            fin_clear = 1'b1;
            to_abort  = 1'b1;
        end else begin
            case (state)
                S_IDLE:     if (run) state_nxt = S_CLEAR;
                S_CLEAR:    state_nxt = S_WAIT_RDY;
                S_WAIT_RDY: begin
                    if (t_ready) begin
                        state_nxt = S_START;
                    end else if (wd_exp) begin
                        state_nxt  = S_FINISH;
                        fin_clear  = 1'b1;
                        to_timeout = 1'b1;
                    end
                end
                S_START:    state_nxt = S_RUN;
                S_RUN: begin
                    if (STOP_ON_FAULT && t_fault) begin
                        state_nxt = S_FINISH;
                        fin_clear = 1'b1;
                    end else if (t_done) begin
                        state_nxt = S_CHECK;
                    end else if (wd_exp) begin
                        state_nxt  = S_FINISH;
                        fin_clear  = 1'b1;
                        to_timeout = 1'b1;
                    end
                end
                S_CHECK: begin
                    if (iters_lat != '0 && iter_inc == iters_lat) state_nxt = S_FINISH;
                    else                                          state_nxt = S_WAIT_RDY;
                end
                S_FINISH:   state_nxt = S_IDLE;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        iter_nxt  = iter_cnt;
        fault_nxt = fault_cnt;
        if (accept) begin
            iter_nxt  = '0;
            fault_nxt = '0;
        end else begin
            if (state == S_CHECK) iter_nxt = iter_inc;
            if (state == S_RUN && t_fault && fault_cnt != CMAX) fault_nxt = fault_cnt + CWIDTH'(1);
        end
        timeout_nxt = accept ? 1'b0 : (timeout | to_timeout);
        aborted_nxt = accept ? 1'b0 : (aborted | to_abort);

        busy_d    = (state_nxt != S_IDLE) && (state_nxt != S_FINISH);
        sdone_d   = (state_nxt == S_FINISH);
        t_clear_d = (state_nxt == S_CLEAR) || fin_clear;
        t_start_d = (state_nxt == S_START);

        spass_d = spass;
        if (accept)                      spass_d = 1'b0;
        else if (state_nxt == S_FINISH)  spass_d = (fault_nxt == '0) && !timeout_nxt && !aborted_nxt;
    end

    // Watchdog reloads on every phase entry and counts down while the phase persists.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd        <= '0;
            iters_lat <= '0;
            iter_cnt  <= '0;
            fault_cnt <= '0;
            timeout   <= 1'b0;
            aborted   <= 1'b0;
            busy      <= 1'b0;
            sdone     <= 1'b0;
            spass     <= 1'b0;
            t_clear   <= 1'b0;
            t_start   <= 1'b0;
        end else begin
            if ((state == S_WAIT_RDY || state == S_RUN) && state_nxt == state)
                wd <= wd - WDW'(1);
            else
                wd <= WD_LOAD;
            if (accept) iters_lat <= iters;
            iter_cnt  <= iter_nxt;
            fault_cnt <= fault_nxt;
            timeout   <= timeout_nxt;
            aborted   <= aborted_nxt;
            busy      <= busy_d;
            sdone     <= sdone_d;
            spass     <= spass_d;
            t_clear   <= t_clear_d;
            t_start   <= t_start_d;
        end
    end

endmodule
